// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared widths, divisor floor and clamp helper for the programmable divider
package clk_div_pkg;
    localparam int DIV_W_DEF = 8;
    localparam int unsigned DIV_MIN = 2;
    function automatic int unsigned clamp_div(input int unsigned d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction
endpackage

// File: rtl/clk_div_prog_if.sv
// clk_div_prog_if: control/status bundle of the programmable clock divider
interface clk_div_prog_if #(parameter int DIV_W = clk_div_pkg::DIV_W_DEF);
    logic             EN;
    logic [DIV_W-1:0] DIV;
    logic             DIV_LD;
    logic             CLKOUT;
    logic             CE_PULSE;
    logic             DIV_PEND;
    logic [DIV_W-1:0] DIV_ACT;
    modport master (output EN, DIV, DIV_LD, input CLKOUT, CE_PULSE, DIV_PEND, DIV_ACT);
    modport slave  (input EN, DIV, DIV_LD, output CLKOUT, CE_PULSE, DIV_PEND, DIV_ACT);
endinterface

// File: rtl/clk_div_core.sv
// clk_div_core: period counter with wrap/fall compares driving the divided clock and CE strobe
module clk_div_core #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] n,
    output logic             clkout,
    output logic             ce,
    output logic             wrap
);
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] h;
    logic             fall;
    assign h    = n >> 1;
    assign wrap = en && (cnt == n - DIV_W'(1));
    assign fall = en && (cnt == h - DIV_W'(1)) && !wrap;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            clkout <= 1'b0;
            ce     <= 1'b0;
        end else begin
            ce <= wrap;
            if (en) begin
                cnt    <= wrap ? '0 : cnt + DIV_W'(1);
                clkout <= wrap | (clkout & ~fall);
            end
        end
    end
endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable integer clock divider, divisor swaps only at period boundaries.
// Define CLK_DIV_DUTY50_ODD_EN to stretch odd-N high phase by half a CLKIN cycle for 50% duty.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DIV_DEFAULT = 4
) (
    input  logic          CLKIN,
    input  logic          ACLR_L,
    clk_div_prog_if.slave bus
);
    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] pend_val;
    logic [DIV_W-1:0] div_c;
    logic             pend;
    logic             wrap;
    logic             clk_pos;
    assign div_c = DIV_W'(clamp_div(32'(bus.DIV)));
    clk_div_core #(.DIV_W(DIV_W)) u_core (
        .clk    (CLKIN),
        .rst_n  (ACLR_L),
        .en     (bus.EN),
        .n      (div_act),
        .clkout (clk_pos),
        .ce     (bus.CE_PULSE),
        .wrap   (wrap)
    );
    // a load landing on the wrap edge bypasses the pending slot entirely
    always_ff @(posedge CLKIN or negedge ACLR_L) begin
        if (!ACLR_L) begin
            div_act  <= DIV_W'(DIV_DEFAULT);
            pend_val <= '0;
            pend     <= 1'b0;
        end else if (wrap) begin
            div_act <= bus.DIV_LD ? div_c : pend ? pend_val : div_act;
            pend    <= 1'b0;
        end else if (bus.DIV_LD) begin
            pend_val <= div_c;
            pend     <= 1'b1;
        end
    end
    assign bus.DIV_ACT  = div_act;
    assign bus.DIV_PEND = pend;
`ifdef CLK_DIV_DUTY50_ODD_EN
    logic clk_neg;
    always_ff @(negedge CLKIN or negedge ACLR_L) begin
        if (!ACLR_L) clk_neg <= 1'b0;
        else         clk_neg <= clk_pos;
    end
    assign bus.CLKOUT = clk_pos | (div_act[0] & clk_neg);
`else
    assign bus.CLKOUT = clk_pos;
`endif
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed checks of clk_div_prog reset, divisor loading, freeze and duty
module tb_clk_div_prog;
    logic clkin = 1'b0;
    logic aclr_l;
    int   checks = 0;
    int   failures = 0;
    int   hi;

    clk_div_prog_if #(.DIV_W(8)) bus ();

    clk_div_prog #(.DIV_W(8), .DIV_DEFAULT(4)) dut (
        .CLKIN  (clkin),
        .ACLR_L (aclr_l),
        .bus    (bus)
    );

    always #5 clkin = ~clkin;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // one CLKIN rising edge, then settle to mid-low phase where both flops have updated
    task automatic step();
        @(posedge clkin);
        @(negedge clkin);
        #1;
    endtask

    task automatic run(input int n, input logic [15:0] cv, input logic [15:0] ev, input string tag);
        for (int i = 0; i < n; i++) begin
            step();
            chk({tag, "_clk"}, 32'(bus.CLKOUT), 32'(cv[i]));
            chk({tag, "_ce"}, 32'(bus.CE_PULSE), 32'(ev[i]));
        end
    endtask

    initial begin
        aclr_l = 1'b0;
        bus.EN = 1'b0;
        bus.DIV = '0;
        bus.DIV_LD = 1'b0;
        repeat (2) step();
        chk("rst_clk", 32'(bus.CLKOUT), 0);
        chk("rst_ce", 32'(bus.CE_PULSE), 0);
        chk("rst_pend", 32'(bus.DIV_PEND), 0);
        chk("rst_act", 32'(bus.DIV_ACT), 4);
        aclr_l = 1'b1;
        bus.EN = 1'b1;
        // default N=4: rise on 4th edge, 2 high / 2 low
        run(12, 16'b100110011000, 16'b100010001000, "t1");
        chk("t1_act", 32'(bus.DIV_ACT), 4);
        // load 7 at cnt=1, applied at the next wrap
        step();
        bus.DIV = 8'd7;
        bus.DIV_LD = 1'b1;
        step();
        bus.DIV_LD = 1'b0;
        chk("t2_pend_a", 32'(bus.DIV_PEND), 1);
        chk("t2_act_old", 32'(bus.DIV_ACT), 4);
        chk("t2_clk_fall", 32'(bus.CLKOUT), 0);
        step();
        chk("t2_pend_b", 32'(bus.DIV_PEND), 1);
        step();
        chk("t2_act_new", 32'(bus.DIV_ACT), 7);
        chk("t2_pend_clr", 32'(bus.DIV_PEND), 0);
        chk("t2_rise", 32'(bus.CLKOUT), 1);
        chk("t2_ce", 32'(bus.CE_PULSE), 1);
        run(7, 16'b1000011, 16'b1000000, "t2");
        // DIV 0 then 1 both clamp to 2
        bus.DIV = 8'd0;
        bus.DIV_LD = 1'b1;
        step();
        bus.DIV = 8'd1;
        step();
        bus.DIV_LD = 1'b0;
        chk("t3_pend", 32'(bus.DIV_PEND), 1);
        chk("t3_act_old", 32'(bus.DIV_ACT), 7);
        repeat (4) step();
        chk("t3_low", 32'(bus.CLKOUT), 0);
        step();
        chk("t3_act", 32'(bus.DIV_ACT), 2);
        chk("t3_pend_clr", 32'(bus.DIV_PEND), 0);
        chk("t3_rise", 32'(bus.CLKOUT), 1);
        run(4, 16'b1010, 16'b1010, "t3");
        // load 5 exactly on the wrap edge: applied at once
        step();
        bus.DIV = 8'd5;
        bus.DIV_LD = 1'b1;
        step();
        bus.DIV_LD = 1'b0;
        chk("t4_act5", 32'(bus.DIV_ACT), 5);
        chk("t4_pend0", 32'(bus.DIV_PEND), 0);
        chk("t4_rise", 32'(bus.CLKOUT), 1);
        chk("t4_ce", 32'(bus.CE_PULSE), 1);
        run(5, 16'b10001, 16'b10000, "t4a");
        // 6 pending then overwritten by 9
        bus.DIV = 8'd6;
        bus.DIV_LD = 1'b1;
        step();
        bus.DIV = 8'd9;
        step();
        bus.DIV_LD = 1'b0;
        chk("t4_pend", 32'(bus.DIV_PEND), 1);
        chk("t4_act_hold", 32'(bus.DIV_ACT), 5);
        repeat (3) step();
        chk("t4_act9", 32'(bus.DIV_ACT), 9);
        chk("t4_pend_clr", 32'(bus.DIV_PEND), 0);
        chk("t4_rise9", 32'(bus.CLKOUT), 1);
        // freeze 10 edges in the high phase of N=9, load 3 while frozen
        repeat (2) step();
        chk("t5_high", 32'(bus.CLKOUT), 1);
        bus.EN = 1'b0;
        step();
        bus.DIV = 8'd3;
        bus.DIV_LD = 1'b1;
        step();
        bus.DIV_LD = 1'b0;
        chk("t5_pend", 32'(bus.DIV_PEND), 1);
        chk("t5_act_hold", 32'(bus.DIV_ACT), 9);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t5_frz_clk", 32'(bus.CLKOUT), 1);
            chk("t5_frz_ce", 32'(bus.CE_PULSE), 0);
        end
        bus.EN = 1'b1;
        run(7, 16'b1000001, 16'b1000000, "t5");
        chk("t5_act3", 32'(bus.DIV_ACT), 3);
        chk("t5_pend_clr", 32'(bus.DIV_PEND), 0);
        bus.EN = 1'b0;
        step();
        chk("t5_ce_off", 32'(bus.CE_PULSE), 0);
        chk("t5_clk_hold", 32'(bus.CLKOUT), 1);
        bus.EN = 1'b1;
        run(3, 16'b100, 16'b100, "t5c");
        // load on wrap overrides an older pending value (and clamps 0)
        bus.DIV = 8'd6;
        bus.DIV_LD = 1'b1;
        step();
        bus.DIV_LD = 1'b0;
        step();
        bus.DIV = 8'd0;
        bus.DIV_LD = 1'b1;
        step();
        bus.DIV_LD = 1'b0;
        chk("t4_ovr_act", 32'(bus.DIV_ACT), 2);
        chk("t4_ovr_pend", 32'(bus.DIV_PEND), 0);
        chk("t4_ovr_clk", 32'(bus.CLKOUT), 1);
        // N=6 with 3 pending, async reset mid-period
        bus.DIV = 8'd6;
        bus.DIV_LD = 1'b1;
        step();
        bus.DIV_LD = 1'b0;
        step();
        chk("t6_act6", 32'(bus.DIV_ACT), 6);
        bus.DIV = 8'd3;
        bus.DIV_LD = 1'b1;
        step();
        bus.DIV_LD = 1'b0;
        step();
        chk("t6_pre_clk", 32'(bus.CLKOUT), 1);
        chk("t6_pre_pend", 32'(bus.DIV_PEND), 1);
        #2;
        aclr_l = 1'b0;
        #1;
        chk("t6_clk", 32'(bus.CLKOUT), 0);
        chk("t6_ce", 32'(bus.CE_PULSE), 0);
        chk("t6_pend", 32'(bus.DIV_PEND), 0);
        chk("t6_act", 32'(bus.DIV_ACT), 4);
        step();
        aclr_l = 1'b1;
        run(4, 16'b1000, 16'b1000, "t6");
        chk("t6_act_after", 32'(bus.DIV_ACT), 4);
        // N=5 duty over 10 half-periods starting just after the rise
        bus.DIV = 8'd5;
        bus.DIV_LD = 1'b1;
        step();
        bus.DIV_LD = 1'b0;
        repeat (3) step();
        chk("t7_act5", 32'(bus.DIV_ACT), 5);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            hi += int'(bus.CLKOUT);
            @(clkin);
            #1;
        end
`ifdef CLK_DIV_DUTY50_ODD_EN
        chk("t7_duty_half", 32'(hi), 5);
`else
        chk("t7_duty_half", 32'(hi), 4);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
Runtime-programmable integer clock divider, successor to the fixed divide-by-4 pixel-clock generator in the VGA path. It produces a divided clock CLKOUT and a single-cycle clock-enable strobe CE_PULSE. Downstream logic should prefer the strobe and stay on CLKIN. The divisor can change at run time without glitches; a change takes effect only at a period boundary. Default configuration yields 25 MHz from 100 MHz.

Parameters:
DIV_W, 8, width of divisor and internal counter
DIV_DEFAULT, 4, divisor loaded at reset; must satisfy 2 <= DIV_DEFAULT <= 2^DIV_W-1

Ports:
CLKIN  input  1  system clock
ACLR_L  input  1  asynchronous active-low reset
EN  input  1  count enable; low freezes divider
DIV  input  DIV_W  requested divisor N
DIV_LD  input  1  one-cycle request to load DIV
CLKOUT  output  1  divided clock (registered)
CE_PULSE  output  1  high for one CLKIN cycle coincident with the CLKOUT rising edge
DIV_PEND  output  1  a loaded divisor is waiting for the next period boundary
DIV_ACT  output  DIV_W  divisor currently in effect

Behaviour:
- Reset (ACLR_L=0, asynchronous):
  - cnt=0, CLKOUT=0, CE_PULSE=0, DIV_PEND=0.
  - DIV_ACT=DIV_DEFAULT, pending register=0.
  - Reset mid-period aborts the period immediately.
- Let N=DIV_ACT and H=floor(N/2). The counter cnt runs 0..N-1 and advances once per CLKIN edge while EN=1.
- Wrap edge (cnt==N-1):
  - cnt<=0, CLKOUT<=1, CE_PULSE<=1.
  - If a divisor is pending, DIV_ACT<=pending and DIV_PEND<=0.
- Fall edge (cnt==H-1, not a wrap): CLKOUT<=0.
- All other edges: CE_PULSE<=0; CLKOUT holds.
- Resulting waveform: CLKOUT is high H cycles and low N-H cycles.
  - First rising edge occurs on the Nth enabled CLKIN edge after reset release.
  - N=4 gives a 2-high/2-low pattern, identical to the legacy divider.
- EN=0: cnt, CLKOUT and DIV_ACT hold; CE_PULSE forced 0 on the next edge. DIV_LD is still accepted.
- DIV_LD capture:
  - DIV values 0 and 1 are clamped to 2.
  - The clamped value goes into the pending register and DIV_PEND<=1 on the next edge.
- DIV_LD on the wrap edge itself: the clamped DIV is applied directly as the new DIV_ACT at that wrap; DIV_PEND stays 0. It overrides any older pending value.
- DIV_LD while pending: the pending value is overwritten; the last load wins.
- Loading a value equal to DIV_ACT is legal; pending still goes high and clears at the wrap.
- No glitches: the period in progress always completes with the old N.

Optional Feature:
CLK_DIV_DUTY50_ODD_EN
- Defined:
  - Adds a negedge-CLKIN flop that samples the posedge CLKOUT register, with the same async reset.
  - For odd N, CLKOUT = posedge register OR negedge register, giving an exact 50% duty (high N/2 cycles).
  - For even N, the negedge path is gated off.
  - CE_PULSE is unchanged.
- Undefined: odd-N duty is H/N, with no negedge logic.

Decomposition:
- Package clk_div_pkg:
  - DIV_W default
  - DIV_MIN=2
  - function clamp_div() implementing the <2 -> 2 rule
- Sub-module clk_div_core: counter, wrap/fall compare, CLKOUT/CE_PULSE registers; N comes in as an input.
- Top clk_div_prog: DIV_LD capture, pending/apply logic, and the optional duty-50 path.

Test Plan:
1. Reset release, EN=1, default N=4 -> CLKOUT rises on 4th CLKIN edge; steady pattern 2 high/2 low; CE_PULSE once per 4 cycles aligned to the rise.
2. DIV=7, DIV_LD pulsed mid-period at cnt=1 -> DIV_PEND=1 until the wrap; current period finishes at 4; following periods 7 cycles, 3 high/4 low; DIV_ACT=7 after the wrap.
3. DIV=0 then DIV=1 loaded -> both clamp; DIV_ACT=2; CLKOUT toggles every cycle (1 high/1 low).
4. DIV_LD with DIV=5 exactly on the wrap edge, then again with DIV=9 while a 6 is pending -> 5 applied immediately with DIV_PEND=0; in the second case 9 is applied (last load wins).
5. EN held low 10 cycles mid-high-phase -> CLKOUT and cnt frozen, CE_PULSE=0; resumes and completes the period with the remaining count.
6. ACLR_L pulsed low mid-period with N=6 and a pending 3 -> outputs immediately 0, DIV_ACT=4, DIV_PEND=0. With CLK_DIV_DUTY50_ODD_EN and N=5: CLKOUT high exactly 2.5 CLKIN periods.
